parking_pass_entry: RTL and testbench

- Front-end stage directly upstream of the car-parking FSM.
- Debounces the raw entrance and exit sensors.
- Collects a two-digit password from a keypad strobe interface and presents it to the FSM as pass1/pass2 with a one-cycle pass_valid pulse.
- Applies an inactivity timeout so a stalled entry does not hold stale digits.

---
 rtl/parking_pass_entry.sv | 114 +++++++++++
 tb/tb_parking_pass_entry.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/parking_pass_entry.sv
// parking_pass_entry: sensor debounce, two-digit keypad capture with timeout, feeding the parking FSM.
// Optional PARKING_KEY_ECHO_EN adds echo_seg, a 7-segment echo of the last accepted digit.
module parking_pass_entry #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_entrance_raw,
  input  logic       sensor_exit_raw,
  input  logic       key_strobe,
  input  logic [1:0] key_digit,
  input  logic       key_clear,
  output logic       sensor_entrance,
  output logic       sensor_exit,
  output logic [1:0] pass1,
  output logic [1:0] pass2,
  output logic       pass_valid,
  output logic       entry_timeout,
  output logic [1:0] digit_count
`ifdef PARKING_KEY_ECHO_EN
  ,
  output logic [6:0] echo_seg
`endif
);
  typedef enum logic [1:0] {IDLE, GET_D1, GET_D2, PRESENT} state_t;
  state_t state;
  logic [1:0] raw, deb;
  logic [7:0] cnt [2];
  logic key_d, ent_d, key_evt, collecting, expired;
  logic [15:0] tcnt;
  assign raw = {sensor_exit_raw, sensor_entrance_raw};
  assign sensor_entrance = deb[0];
  assign sensor_exit = deb[1];
  assign key_evt = key_strobe & ~key_d;
  assign collecting = (state == GET_D1) || (state == GET_D2);
  assign expired = collecting && (tcnt == 16'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (reset) begin
        deb[i] <= 1'b0;
        cnt[i] <= '0;
      end else if (raw[i] == deb[i]) cnt[i] <= '0;
      else if (cnt[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
        deb[i] <= raw[i];
        cnt[i] <= '0;
      end else cnt[i] <= cnt[i] + 8'd1;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      key_d <= 1'b0;
      ent_d <= 1'b0;
      tcnt <= '0;
      pass1 <= '0;
      pass2 <= '0;
      pass_valid <= 1'b0;
      entry_timeout <= 1'b0;
      digit_count <= '0;
    end else begin
      key_d <= key_strobe;
      ent_d <= sensor_entrance;
      pass_valid <= 1'b0;
      entry_timeout <= 1'b0;
      tcnt <= (key_evt || key_clear) ? '0 : tcnt + 16'd1;
      if (expired) begin
        state <= IDLE;
        entry_timeout <= 1'b1;
        pass1 <= '0;
        pass2 <= '0;
        digit_count <= '0;
      end else
        case (state)
          IDLE:
            if (sensor_entrance && !ent_d) begin
              state <= GET_D1;
              tcnt <= '0;
            end
          GET_D1:
            if (key_evt && !key_clear) begin
              pass1 <= key_digit;
              digit_count <= 2'd1;
              state <= GET_D2;
            end
          GET_D2:
            if (key_clear) begin
              pass1 <= '0;
              digit_count <= '0;
              state <= GET_D1;
            end else if (key_evt) begin
              pass2 <= key_digit;
              digit_count <= 2'd2;
              pass_valid <= 1'b1;
              state <= PRESENT;
            end
          default: begin
            digit_count <= '0;
            tcnt <= '0;
            state <= sensor_entrance ? GET_D1 : IDLE;
          end
        endcase
    end
`ifdef PARKING_KEY_ECHO_EN
  logic [6:0] seg;
  always_comb
    seg = (key_digit == 2'd0) ? 7'b1000000 :
          (key_digit == 2'd1) ? 7'b1111001 :
          (key_digit == 2'd2) ? 7'b0100100 : 7'b0110000;
  always_ff @(posedge clk)
    if (reset || expired || (collecting && key_clear) || (state == PRESENT && !sensor_entrance))
      echo_seg <= 7'b1111111;
    else if (collecting && key_evt)
      echo_seg <= seg;
`endif
endmodule

// File: tb/tb_parking_pass_entry.sv
// tb_parking_pass_entry: randomized entry sessions scored against a transaction-level model of the keypad front end.
module tb_parking_pass_entry;
  localparam int T = 8;
  logic clk = 1'b0, reset = 1'b1;
  logic sensor_entrance_raw = 1'b0, sensor_exit_raw = 1'b0;
  logic key_strobe = 1'b0, key_clear = 1'b0;
  logic [1:0] key_digit = '0;
  logic sensor_entrance, sensor_exit, pass_valid, entry_timeout;
  logic [1:0] pass1, pass2, digit_count;
`ifdef PARKING_KEY_ECHO_EN
  logic [6:0] echo_seg;
`endif

  parking_pass_entry #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .sensor_entrance_raw(sensor_entrance_raw), .sensor_exit_raw(sensor_exit_raw),
    .key_strobe(key_strobe), .key_digit(key_digit), .key_clear(key_clear),
    .sensor_entrance(sensor_entrance), .sensor_exit(sensor_exit),
    .pass1(pass1), .pass2(pass2), .pass_valid(pass_valid),
    .entry_timeout(entry_timeout), .digit_count(digit_count)
`ifdef PARKING_KEY_ECHO_EN
    , .echo_seg(echo_seg)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { bit to; logic [1:0] p1; logic [1:0] p2; } ev_t;
  ev_t exp_q[$];
  ev_t mon_e;
  int checks = 0, errors = 0, cyc = 0, start = 0, nd = 0, a = 0;
  bit active = 1'b0;
  logic [1:0] d1 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void push_ev(input bit to, input logic [1:0] p1, input logic [1:0] p2);
    ev_t e;
    e.to = to;
    e.p1 = p1;
    e.p2 = p2;
    exp_q.push_back(e);
  endfunction

  // Entrance low long enough to drop, then re-qualify; the FSM starts collecting 4 edges after raw rises.
  task automatic restart();
    sensor_entrance_raw = 1'b0;
    tick(6);
    sensor_entrance_raw = 1'b1;
    a = cyc + 1;
    tick(5);
    active = 1'b1;
    nd = 0;
    start = a + 4;
  endtask

  // Idle w cycles, then a strobe (optionally with clear) held h cycles, then one low cycle.
  // A key event is honoured only if it lands fewer than T edges after the last timer restart.
  task automatic act(input bit is_clear, input logic [1:0] dg, input int h, input int w);
    int e;
    e = cyc + 1 + w;
    if (active && e - start >= T) begin
      push_ev(1'b1, 2'd0, 2'd0);
      active = 1'b0;
      nd = 0;
    end
    tick(w);
    if (!active) restart();
    key_strobe = 1'b1;
    key_digit = dg;
    key_clear = is_clear;
    if (is_clear) begin
      nd = 0;
      start = cyc + 1;
    end else if (nd == 0) begin
      d1 = dg;
      nd = 1;
      start = cyc + 1;
    end else begin
      push_ev(1'b0, d1, dg);
      nd = 0;
      start = cyc + 2;
    end
    tick(1);
    key_clear = 1'b0;
    tick(h - 1);
    key_strobe = 1'b0;
    tick(1);
  endtask

  always @(negedge clk)
    if (!reset && (pass_valid || entry_timeout)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event pass_valid=%0b entry_timeout=%0b required=none (cycle %0d)",
                 pass_valid, entry_timeout, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_kind", {pass_valid, entry_timeout}, mon_e.to ? 2 'b01 : 2'b10);
        chk("event_pass1", pass1, mon_e.p1);
        chk("event_pass2", pass2, mon_e.p2);
        chk("event_count", digit_count, mon_e.to ? 0 : 2);
      end
    end

  initial begin
    bit c;
    logic [1:0] dg;
    int h, w;
    tick(2);
    chk("reset_sensors", {sensor_entrance, sensor_exit}, 0);
    chk("reset_pass", {pass1, pass2}, 0);
    chk("reset_flags", {pass_valid, entry_timeout, digit_count}, 0);
`ifdef PARKING_KEY_ECHO_EN
    chk("reset_echo", echo_seg, 7'h7f);
`endif
    reset = 1'b0;
    sensor_entrance_raw = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) sensor_entrance_raw = 1'b0;
      tick(1);
      chk("glitch_filtered", sensor_entrance, 0);
    end
    sensor_entrance_raw = 1'b1;
    sensor_exit_raw = 1'b1;
    a = cyc + 1;
    tick(3);
    chk("deb_ent_early", sensor_entrance, 0);
    chk("deb_exit_early", sensor_exit, 0);
    tick(1);
    chk("deb_ent_latency", sensor_entrance, 1);
    chk("deb_exit_latency", sensor_exit, 1);
    active = 1'b1;
    nd = 0;
    start = a + 4;
    act(0, 2'd1, 1, 1);
    act(0, 2'd2, 1, 0);
    act(0, 2'd1, 5, 0);
    act(0, 2'd0, 1, 0);
    act(0, 2'd2, 1, 0);
    act(1, 2'd3, 1, 0);
    chk("clear_count", digit_count, 0);
    chk("clear_pass1", pass1, 0);
    act(0, 2'd2, 1, 0);
    act(0, 2'd2, 1, 0);
    act(0, 2'd1, 1, 0);
    act(0, 2'd3, 1, 5);
    act(0, 2'd1, 1, 0);
    chk("first_digit_count", digit_count, 1);
    push_ev(1'b1, 2'd0, 2'd0);
    active = 1'b0;
    nd = 0;
    tick(6);
    key_strobe = 1'b1;
    key_digit = 2'd2;
    tick(1);
    key_strobe = 1'b0;
    chk("timeout_pulse", entry_timeout, 1);
    chk("timeout_count", digit_count, 0);
    tick(1);
    chk("timeout_one_cycle", entry_timeout, 0);
    for (int i = 0; i < 3; i++) begin
      key_strobe = 1'b1;
      tick(1);
      key_strobe = 1'b0;
      tick(1);
    end
    tick(10);
    chk("idle_after_timeout_count", digit_count, 0);
    act(0, 2'd3, 1, 0);
    chk("mid_entry_count", digit_count, 1);
    reset = 1'b1;
    tick(1);
    chk("mid_reset_sensors", {sensor_entrance, sensor_exit}, 0);
    chk("mid_reset_outputs", {pass1, pass2, pass_valid, entry_timeout, digit_count}, 0);
`ifdef PARKING_KEY_ECHO_EN
    chk("mid_reset_echo", echo_seg, 7'h7f);
`endif
    reset = 1'b0;
    sensor_entrance_raw = 1'b0;
    active = 1'b0;
    nd = 0;
    tick(3);
    chk("exit_requalify_early", sensor_exit, 0);
    tick(1);
    chk("exit_requalify", sensor_exit, 1);
    repeat (60) begin
      c = ($urandom_range(0, 5) == 0);
      dg = 2'($urandom_range(0, 3));
      h = $urandom_range(1, 3);
      w = ($urandom_range(0, 7) == 0) ? 7 : $urandom_range(0, 3);
      act(c, dg, h, w);
    end
    if (active) push_ev(1'b1, 2'd0, 2'd0);
    active = 1'b0;
    tick(12);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
